// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // Ceiling log2 of n, meant for n >= 2. Bounded loop so it elaborates as a constant.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping modulo N.
module fifo_wr_arbiter_rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned LGN = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [LGN-1:0] ptr_i,
  output logic           any_o,
  output logic [LGN-1:0] idx_o
);

  // Scan ptr+1, ptr+2, ... ptr+N (the last one is ptr itself) and keep the first hit.
  always_comb begin
    int unsigned cand;
    any_o = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(ptr_i) + off) % N;
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = LGN'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port among NIN requesters.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NIN      = 4,
  parameter int unsigned BW       = 8,
  parameter int unsigned LGFLEN   = 4,
  parameter int unsigned MINSPACE = 1,
  parameter int unsigned LGMAXPKT = 4,
  localparam int unsigned LGNIN   = clog2(NIN)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NIN-1:0]    i_valid,
  input  logic [NIN*BW-1:0] i_data,
  input  logic [NIN-1:0]    i_last,
  output logic [NIN-1:0]    o_ready,
  output logic              o_wr,
  output logic [BW-1:0]     o_data,
  input  logic              i_full,
  input  logic [LGFLEN:0]   i_fill,
  output logic              o_busy,
  output logic [LGNIN-1:0]  o_grant_id,
  output logic              o_trunc
);

  localparam int unsigned     Depth     = 1 << LGFLEN;
  localparam logic [LGFLEN:0] DepthW    = (LGFLEN + 1)'(Depth);
  localparam logic [LGFLEN:0] MinSpaceW = (LGFLEN + 1)'(MINSPACE);
  localparam logic [LGMAXPKT:0] MaxPktW = (LGMAXPKT + 1)'(1 << LGMAXPKT);

  state_e             state_q, state_d;
  logic [LGNIN-1:0]   grant_id_q, grant_id_d;
  logic [LGNIN-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LGMAXPKT:0]  cnt_q, cnt_d;
  logic               trunc_q, trunc_d;

  logic [LGFLEN:0]    free;
  logic               space_ok;
  logic               pick_any;
  logic [LGNIN-1:0]   pick_idx;
  logic [NIN-1:0]     gnt_oh;
  logic               lane_valid;
  logic               lane_last;

  // Free slots; an out-of-range fill reads as no space at all.
  always_comb begin
    free     = (i_fill > DepthW) ? '0 : (DepthW - i_fill);
    space_ok = (free >= MinSpaceW);
  end

  fifo_wr_arbiter_rr_pick #(
    .N   (NIN),
    .LGN (LGNIN)
  ) u_rr_pick (
    .req_i (i_valid),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // Decode the current grantee and mux its lane onto the FIFO write data.
  always_comb begin
    gnt_oh = '0;
    o_data = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      gnt_oh[k] = (grant_id_q == LGNIN'(k));
      if (gnt_oh[k]) o_data = i_data[k*BW +: BW];
    end
    lane_valid = |(i_valid & gnt_oh);
    lane_last  = |(i_last & gnt_oh);
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    trunc_d    = 1'b0;
    o_ready    = '0;
    o_wr       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Space is only checked here; once granted, only i_full throttles.
        if (pick_any && space_ok) begin
          grant_id_d = pick_idx;
          cnt_d      = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        o_ready = i_full ? '0 : gnt_oh;
        o_wr    = lane_valid && !i_full;
        if (o_wr) begin
          cnt_d = cnt_q + 1'b1;
          if (lane_last) begin
            state_d  = StIdle;
            rr_ptr_d = grant_id_q;
          end else if (cnt_d == MaxPktW) begin
            state_d  = StIdle;
            rr_ptr_d = grant_id_q;
            trunc_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      grant_id_q <= '0;
      rr_ptr_q   <= LGNIN'(NIN - 1);
      cnt_q      <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  assign o_busy     = (state_q == StGrant);
  assign o_grant_id = grant_id_q;
  assign o_trunc    = trunc_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the write port of one synchronous FIFO between NIN requesters.
- Each requester presents valid/data/last beats. A grant is held until the requester's last beat is accepted, or until a maximum-length cut-off.
- Sits directly in front of the FIFO write port. It reads the FIFO's full and fill outputs to gate grants.

Parameters:
- NIN, 4: number of requesters; legal range 2..16. LGNIN = clog2(NIN), local.
- BW, 8: data width per beat.
- LGFLEN, 4: log2 of the downstream FIFO depth; fill width is LGFLEN+1.
- MINSPACE, 1: free FIFO slots required before a new grant is issued; legal range 1..2^LGFLEN.
- LGMAXPKT, 4: a packet is force-released after 2^LGMAXPKT accepted beats.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset: asynchronous assertion, active low.
- i_valid  in  NIN  per-requester beat valid.
- i_data  in  NIN*BW  per-requester data; requester k occupies bits [k*BW +: BW].
- i_last  in  NIN  per-requester last beat of packet.
- o_ready  out  NIN  per-requester beat accepted this cycle when paired with i_valid.
- o_wr  out  1  FIFO write strobe.
- o_data  out  BW  FIFO write data.
- i_full  in  1  FIFO full.
- i_fill  in  LGFLEN+1  FIFO occupancy.
- o_busy  out  1  a grant is active.
- o_grant_id  out  LGNIN  index of the current or most recent grantee.
- o_trunc  out  1  one-cycle pulse when a packet is force-released at the length limit.

Behaviour:
- Reset values (asynchronous, on !i_reset_n):
  - state = IDLE, o_busy = 0, o_grant_id = 0, rr_ptr = NIN-1, beat counter = 0, o_trunc = 0.
  - o_ready = 0 and o_wr = 0 follow combinationally from state.
- Free-space arithmetic:
  - free = 2^LGFLEN - i_fill, computed at LGFLEN+1 bits.
  - An i_fill value above 2^LGFLEN is treated as free = 0.
- State IDLE:
  - o_ready = 0, o_wr = 0.
  - If any i_valid and free >= MINSPACE, select the first k with i_valid[k] searching rr_ptr+1, rr_ptr+2, ... modulo NIN.
  - Register o_grant_id = k, clear the beat counter, go to GRANT. o_busy rises on the next cycle.
  - Arbitration latency is exactly one cycle from request to o_ready.
- State GRANT, with g = o_grant_id:
  - o_ready[g] = !i_full; all other o_ready = 0.
  - o_wr = i_valid[g] && !i_full.
  - o_data = i_data[g], a combinational mux. The value is don't-care when o_wr = 0, but is still driven from the granted lane.
  - On every accepted beat (o_wr = 1) the beat counter increments.
- Grant release:
  - On an accepted beat with i_last[g], or on the accepted beat that makes the count equal 2^LGMAXPKT without i_last: go to IDLE and set rr_ptr = g.
  - o_trunc pulses on the cycle after a length-limit release that had no i_last.
  - After a truncation, the requester's remaining beats form a new packet that competes normally.
- Grant hold rules:
  - While in GRANT, other requesters' valids are ignored.
  - A stalled grantee (i_valid[g] = 0) keeps the grant indefinitely.
  - MINSPACE is checked only at grant time. Backpressure after that comes only from i_full.
- Back-to-back packets always have one IDLE bubble cycle between them.
- FIFO read-while-full: if the downstream FIFO is configured to accept writes on full, it lowers i_full combinationally. The arbiter simply follows i_full.
- Reset mid-packet: the grant is dropped immediately. No partial-packet recovery; upstream and downstream are reset together.
- Width: the beat counter is LGMAXPKT+1 bits wide and never wraps, because release occurs at 2^LGMAXPKT.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE = 1'b0, GRANT = 1'b1);
  - a constant function clog2 for LGNIN.
- One natural sub-module, rr_pick. It is purely combinational: inputs are a request vector and rr_ptr; outputs are any and an index. It is reusable by other arbiters in the codebase.
- All registers stay in fifo_wr_arbiter.

Test Plan:
1. Reset, then i_valid = 4'b0001 with a 3-beat packet (last on beat 3), FIFO empty. Required: o_busy = 1 one cycle after valid; 3 consecutive o_wr with lane-0 data; o_grant_id = 0; return to IDLE.
2. All four lanes valid continuously, 2-beat packets each. Required: grant order 0,1,2,3,0; one bubble cycle between packets.
3. Lane 2 granted; i_full asserts for 5 cycles mid-packet. Required: o_ready[2] = 0 and o_wr = 0 for those 5 cycles; no beat lost or duplicated; the grant is not released.
4. MINSPACE = 4, i_fill = 13 (free = 3), lane 1 valid. Required: no grant. After i_fill drops to 12, the grant issues the next cycle.
5. LGMAXPKT = 2, lane 3 streams 6 beats with no last. Required: release after beat 4; o_trunc pulses once; lane 3 is re-granted, or another lane wins if it is requesting.
6. Assert i_reset_n = 0 asynchronously during lane-1 beat 2. Required: o_busy, o_ready and o_wr drop immediately. After release, the first grant goes to lane 0 if it is requesting.
